// File: rtl/lsu_subword.sv
// Load/store unit that adds byte and halfword access on top of a word-only
// data memory: sign/zero-extending loads, read-modify-write sub-word stores,
// access checking at accept time, and a core stall while a request is busy.
module lsu_subword #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Last value of the per-phase counter; each memory phase is held this+1 cycles.
  localparam logic [3:0]  LAST_CNT  = 4'(WAIT_CYCLES);
  localparam logic [31:0] WORDS_LIM = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request captured on the accept edge; inputs are ignored afterwards.
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        req_err;
  logic        f3_legal;
  logic        f3_store_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        in_mem_phase;
  logic        phase_last;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_word;
  logic [31:0] store_word;

  assign accept       = (state_q == S_IDLE) && req_valid;
  assign in_mem_phase = (state_q == S_RD) || (state_q == S_RMW_RD) || (state_q == S_WR);
  assign phase_last   = (cnt_q == LAST_CNT);
  assign resp_rdata   = rdata_q;

  // Access check on the live request inputs, used only on the accept edge.
  always_comb begin
    f3_legal     = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                   (req_funct3 == 3'b101);
    f3_store_bad = req_we && req_funct3[2];
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= WORDS_LIM);
    req_err      = !f3_legal || f3_store_bad || misaligned || out_of_range;
  end

  // State register and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter restarts at zero whenever a new state is entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                     state_d = S_DONE;
          else if (!req_we)                state_d = S_RD;
          else if (req_funct3 == 3'b010)   state_d = S_WR;
          else                             state_d = S_RMW_RD;
        end
      end
      S_RD:     if (phase_last) state_d = S_DONE;
      S_RMW_RD: if (phase_last) state_d = S_WR;
      S_WR:     if (phase_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = (in_mem_phase && (state_d == state_q)) ? cnt_q + 4'd1 : 4'd0;
  end

  // Request latch, merge word and load result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  // Lane extraction and sign/zero extension of the word returned by memory.
  always_comb begin
    lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q[1:0])
      2'b00:   load_word = {{24{!f3_q[2] && lane_byte[7]}}, lane_byte};
      2'b01:   load_word = {{16{!f3_q[2] && lane_half[15]}}, lane_half};
      default: load_word = mem_rdata;
    endcase
  end

  // Write-word assembly: each byte lane takes either new store data or the old word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_hit;
    logic [7:0] lane_src;
    assign lane_hit = (f3_q[1:0] == 2'b00) ? (addr_q[1:0] == 2'(gi))
                                           : (addr_q[1] == 1'(gi / 2));
    assign lane_src = (f3_q[1:0] == 2'b00) ? wdata_q[7:0] : wdata_q[8*(gi%2) +: 8];
    assign store_word[8*gi +: 8] = (f3_q == 3'b010) ? wdata_q[8*gi +: 8]
                                 : (lane_hit ? lane_src : merge_q[8*gi +: 8]);
  end

  // Merge capture at the end of the RMW read, and load result update rules.
  always_comb begin
    merge_d = merge_q;
    rdata_d = rdata_q;
    if ((state_q == S_RMW_RD) && phase_last) merge_d = mem_rdata;
    if ((state_q == S_RD) && phase_last)        rdata_d = load_word;
    else if (accept && req_err)                 rdata_d = 32'd0;
    else if ((state_q == S_WR) && phase_last)   rdata_d = 32'd0;
  end

  // Handshake and memory strobes decoded from the current state.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    stall      = accept || in_mem_phase;
    resp_valid = (state_q == S_DONE);
    resp_err   = (state_q == S_DONE) && err_q;
    mem_read   = (state_q == S_RD) || (state_q == S_RMW_RD);
    mem_write  = (state_q == S_WR) && phase_last;
    mem_addr   = in_mem_phase ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wdata  = (state_q == S_WR) ? store_word : 32'd0;
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: three instances (WAIT_CYCLES 0, 2, 3) each on its own
// word memory, directed scenarios plus randomized traffic against a word-level model.
module tb_lsu_subword;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n      [NI];
  logic        req_valid  [NI];
  logic        req_we     [NI];
  logic [2:0]  req_funct3 [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        req_ready  [NI];
  logic        stall      [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic        mem_read   [NI];
  logic        mem_write  [NI];
  logic [31:0] mem_addr   [NI];
  logic [31:0] mem_wdata  [NI];
  logic [31:0] mem_rdata  [NI];

  bit   [31:0] mem        [NI][256];
  bit   [31:0] model_mem  [NI][256];
  int          wr_count   [NI];
  logic        bd_we      [NI];
  logic [7:0]  bd_idx     [NI];
  logic [31:0] bd_data    [NI];

  int checks = 0;
  int passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    lsu_subword #(
      .MEM_WORDS  (256),
      .WAIT_CYCLES((gi == 0) ? 0 : (gi == 1) ? 2 : 3)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[gi]),
      .req_valid  (req_valid[gi]),
      .req_we     (req_we[gi]),
      .req_funct3 (req_funct3[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .req_ready  (req_ready[gi]),
      .stall      (stall[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_rdata (resp_rdata[gi]),
      .resp_err   (resp_err[gi]),
      .mem_read   (mem_read[gi]),
      .mem_write  (mem_write[gi]),
      .mem_addr   (mem_addr[gi]),
      .mem_wdata  (mem_wdata[gi]),
      .mem_rdata  (mem_rdata[gi])
    );
    assign mem_rdata[gi] = mem[gi][mem_addr[gi][9:2]];
  end

  // Word memories with a backdoor preload port, plus write-pulse counters.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (bd_we[i]) mem[i][bd_idx[i]] <= bd_data[i];
      else if (mem_write[i]) mem[i][mem_addr[i][9:2]] <= mem_wdata[i];
      if (mem_write[i]) wr_count[i] <= wr_count[i] + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (we && f3 >= 4) bad = 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) bad = 1'b1;
    if (f3 == 2 && (a % 4) != 0) bad = 1'b1;
    if ((a / 4) >= 256) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [31:0] a);
    int unsigned b, h;
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (16 * ((a / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] wd);
    int unsigned sh, mask;
    if (f3 == 2) return wd;
    if (f3 == 0) begin
      sh = 8 * (a % 4);
      mask = 255 << sh;
      return (old & ~mask) | ((wd % 256) << sh);
    end
    sh = 16 * ((a / 2) % 2);
    mask = 65535 << sh;
    return (old & ~mask) | ((wd % 65536) << sh);
  endfunction

  function automatic int exp_lat(input int k, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (exp_err(we, f3, a)) return 1;
    if (!we || f3 == 2) return 2 + wait_of(k);
    return 3 + 2 * wait_of(k);
  endfunction

  // ---------------- drivers ----------------
  task automatic preload(input int k, input int idx, input logic [31:0] v);
    bd_we[k]   = 1'b1;
    bd_idx[k]  = 8'(idx);
    bd_data[k] = v;
    @(posedge clk);
    @(negedge clk);
    bd_we[k] = 1'b0;
    model_mem[k][idx] = v;
  endtask

  // Issues one request from an idle negedge and records what the DUT did until
  // the response; returns in the idle cycle that follows.
  task automatic run_txn(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit perturb,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int nwr, output bit rd_seen, output bit both_seen,
                         output logic [63:0] stall_bits, output logic [31:0] saddr,
                         output bit saddr_var, output logic ready_after);
    int  w0;
    bit  first;
    w0 = wr_count[k];
    req_valid[k] = 1'b1; req_we[k] = we; req_funct3[k] = f3;
    req_addr[k] = a; req_wdata[k] = wd;
    #1;
    stall_bits = '0; stall_bits[0] = stall[k];
    rd_seen = 0; both_seen = 0; saddr = 0; saddr_var = 0; first = 1;
    lat = -1; rdata = 'x; err = 'x;
    if (mem_read[k] || mem_write[k]) both_seen = 1;
    for (int c = 1; c < 60 && lat < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      stall_bits[c] = stall[k];
      if (mem_read[k]) rd_seen = 1;
      if (mem_read[k] && mem_write[k]) both_seen = 1;
      if (mem_read[k] || mem_write[k]) begin
        if (first) saddr = mem_addr[k];
        else if (mem_addr[k] !== saddr) saddr_var = 1;
        first = 0;
      end
      if (resp_valid[k]) begin
        lat = c; rdata = resp_rdata[k]; err = resp_err[k];
      end
      if (c == 1) begin
        req_valid[k] = 1'b0;
        if (perturb) begin
          req_addr[k]   = a ^ 32'h4;
          req_we[k]     = !we;
          req_funct3[k] = 3'($urandom_range(0, 7));
          req_wdata[k]  = $urandom;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    ready_after = req_ready[k];
    nwr = wr_count[k] - w0;
    $display("txn inst=%0d we=%0d f3=%0d addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0d writes=%0d",
             k, we, f3, a, wd, lat, rdata, err, nwr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({resp_valid[k], resp_err[k], mem_read[k], mem_write[k], req_ready[k], stall[k]} !== 6'b000010
          || resp_rdata[k] !== 32'd0 || mem_addr[k] !== 32'd0 || mem_wdata[k] !== 32'd0)
        $display("FAIL reset_outputs inst=%0d got v=%0d e=%0d rd=%0d wr=%0d rdy=%0d st=%0d rdata=%08h addr=%08h wdata=%08h want idle zeros with ready=1",
                 k, resp_valid[k], resp_err[k], mem_read[k], mem_write[k], req_ready[k], stall[k],
                 resp_rdata[k], mem_addr[k], mem_wdata[k]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_rmw();
    int          k = 2;
    int          w0;
    logic [31:0] v, wd;
    v  = $urandom;
    wd = $urandom;
    preload(k, 4, v);
    w0 = wr_count[k];
    req_valid[k] = 1'b1; req_we[k] = 1'b1; req_funct3[k] = 3'd0;
    req_addr[k] = 32'h10; req_wdata[k] = wd;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) req_valid[k] = 1'b0;
    end
    checks++;
    if (mem_wdata[k] !== exp_store(v, 3'd0, 32'h10, wd) || mem_write[k] !== 1'b0 || mem_read[k] !== 1'b0)
      $display("FAIL rmw_wr_phase wdata=%08h wr=%0d rd=%0d want wdata=%08h wr=0 rd=0",
               mem_wdata[k], mem_write[k], mem_read[k], exp_store(v, 3'd0, 32'h10, wd));
    else passes++;
    rst_n[k] = 1'b0;
    #1;
    checks++;
    if ({resp_valid[k], resp_err[k], mem_read[k], mem_write[k], req_ready[k], stall[k]} !== 6'b000010
        || resp_rdata[k] !== 32'd0 || mem_addr[k] !== 32'd0 || mem_wdata[k] !== 32'd0)
      $display("FAIL rmw_reset_outputs got v=%0d e=%0d rd=%0d wr=%0d rdy=%0d st=%0d addr=%08h wdata=%08h want reset values",
               resp_valid[k], resp_err[k], mem_read[k], mem_write[k], req_ready[k], stall[k],
               mem_addr[k], mem_wdata[k]);
    else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_count[k] - w0 !== 0 || mem[k][4] !== v)
      $display("FAIL rmw_reset_no_write writes=%0d word4=%08h want writes=0 word4=%08h",
               wr_count[k] - w0, mem[k][4], v);
    else passes++;
    rst_n[k] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_subword_loads();
    logic [31:0] la  [5] = '{32'h11, 32'h12, 32'h13, 32'h12, 32'h10};
    logic [2:0]  lf  [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] lex [5] = '{32'h0000_007F, 32'hFFFF_FFF7, 32'h0000_0080, 32'hFFFF_80F7, 32'h0000_7F01};
    int lat, nwr; logic [31:0] rd, sa; logic er, rdy; bit rs, bs, sv; logic [63:0] sb;
    preload(0, 4, 32'h80F7_7F01);
    for (int i = 0; i < 5; i++) begin
      run_txn(0, 1'b0, lf[i], la[i], 32'd0, 1'b0, lat, rd, er, nwr, rs, bs, sb, sa, sv, rdy);
      checks++;
      if (rd !== lex[i] || er !== 1'b0)
        $display("FAIL load_data[%0d] got rdata=%08h err=%0d want rdata=%08h err=0", i, rd, er, lex[i]);
      else passes++;
      checks++;
      if (lat !== 2 || sb[2:0] !== 3'b011 || nwr !== 0)
        $display("FAIL load_timing[%0d] got lat=%0d stall=%03b writes=%0d want lat=2 stall=011 writes=0",
                 i, lat, sb[2:0], nwr);
      else passes++;
    end
  endtask

  task automatic test_subword_stores();
    logic [31:0] sa_t [2] = '{32'h12, 32'h10};
    logic [2:0]  sf_t [2] = '{3'd0, 3'd1};
    logic [31:0] sw_t [2] = '{32'h0000_00AB, 32'h0000_CAFE};
    logic [31:0] sx_t [2] = '{32'h11AB_3344, 32'h11AB_CAFE};
    int lat, nwr; logic [31:0] rd, sa; logic er, rdy; bit rs, bs, sv; logic [63:0] sb;
    preload(0, 4, 32'h1122_3344);
    for (int i = 0; i < 2; i++) begin
      run_txn(0, 1'b1, sf_t[i], sa_t[i], sw_t[i], 1'b0, lat, rd, er, nwr, rs, bs, sb, sa, sv, rdy);
      model_mem[0][4] = sx_t[i];
      checks++;
      if (mem[0][4] !== sx_t[i])
        $display("FAIL store_word[%0d] got %08h want %08h", i, mem[0][4], sx_t[i]);
      else passes++;
      checks++;
      if (lat !== 3 || nwr !== 1 || rd !== 32'd0 || er !== 1'b0 || bs)
        $display("FAIL store_resp[%0d] got lat=%0d writes=%0d rdata=%08h err=%0d overlap=%0d want 3/1/0/0/0",
                 i, lat, nwr, rd, er, bs);
      else passes++;
    end
  endtask

  task automatic test_errors();
    logic        ew  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ef  [4] = '{3'd2, 3'd1, 3'd4, 3'd2};
    logic [31:0] ea  [4] = '{32'h06, 32'h03, 32'h10, 32'h400};
    int lat, nwr; logic [31:0] rd, sa; logic er, rdy; bit rs, bs, sv; logic [63:0] sb;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, ew[i], ef[i], ea[i], $urandom, 1'b0, lat, rd, er, nwr, rs, bs, sb, sa, sv, rdy);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || rs || bs || nwr !== 0)
        $display("FAIL error_case[%0d] got lat=%0d err=%0d rdata=%08h read=%0d writes=%0d want lat=1 err=1 rdata=0 no strobes",
                 i, lat, er, rd, rs, nwr);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int k = 1;
    int w0, r1, r2;
    logic [31:0] d1, d2;
    logic e2, rdy_idle, st_idle;
    r1 = -1; r2 = -1; d1 = 'x; d2 = 'x; e2 = 'x; rdy_idle = 'x; st_idle = 'x;
    w0 = wr_count[k];
    req_valid[k] = 1'b1; req_we[k] = 1'b1; req_funct3[k] = 3'd2;
    req_addr[k] = 32'h20; req_wdata[k] = 32'hDEAD_BEEF;
    for (int c = 1; c < 40 && r2 < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid[k]) begin
        if (r1 < 0) begin r1 = c; d1 = resp_rdata[k]; end
        else begin r2 = c; d2 = resp_rdata[k]; e2 = resp_err[k]; req_valid[k] = 1'b0; end
      end
      if (r1 >= 0 && c == r1 + 1) begin rdy_idle = req_ready[k]; st_idle = stall[k]; end
      if (c == 1) req_we[k] = 1'b0;
    end
    model_mem[k][8] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    $display("txn inst=%0d back-to-back SW/LW 0x20 -> sw_resp=%0d lw_resp=%0d lw_rdata=%08h writes=%0d",
             k, r1, r2, d2, wr_count[k] - w0);
    checks++;
    if (r1 !== 4 || d1 !== 32'd0)
      $display("FAIL b2b_sw_resp got cycle=%0d rdata=%08h want cycle=4 rdata=0", r1, d1);
    else passes++;
    checks++;
    if (rdy_idle !== 1'b1 || st_idle !== 1'b1)
      $display("FAIL b2b_idle_cycle got ready=%0d stall=%0d want 1/1", rdy_idle, st_idle);
    else passes++;
    checks++;
    if (r2 !== r1 + 5 || d2 !== 32'hDEAD_BEEF || e2 !== 1'b0)
      $display("FAIL b2b_lw_resp got cycle=%0d rdata=%08h err=%0d want cycle=%0d rdata=deadbeef err=0",
               r2, d2, e2, r1 + 5);
    else passes++;
    checks++;
    if (wr_count[k] - w0 !== 1 || mem[k][8] !== 32'hDEAD_BEEF)
      $display("FAIL b2b_write got writes=%0d word8=%08h want 1/deadbeef", wr_count[k] - w0, mem[k][8]);
    else passes++;
  endtask

  task automatic test_input_change();
    int lat, nwr; logic [31:0] rd, sa, v; logic er, rdy; bit rs, bs, sv; logic [63:0] sb;
    v = $urandom;
    preload(0, 2, v);
    run_txn(0, 1'b0, 3'd2, 32'h08, 32'd0, 1'b1, lat, rd, er, nwr, rs, bs, sb, sa, sv, rdy);
    checks++;
    if (sa !== 32'h08 || sv || nwr !== 0 || rd !== v || lat !== 2)
      $display("FAIL input_change got addr=%08h varied=%0d writes=%0d rdata=%08h lat=%0d want 00000008/0/0/%08h/2",
               sa, sv, nwr, rd, lat, v);
    else passes++;
  endtask

  task automatic test_random();
    int lat, nwr, elat, idx; logic [31:0] rd, sa, a, wd, erd; logic er, rdy, we, eerr;
    logic [2:0] f3; bit rs, bs, sv, perturb; logic [63:0] sb, m;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 40; n++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) a = $urandom;
        else if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(256, 259) * 4 + $urandom_range(0, 3));
        else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        wd = $urandom;
        perturb = 1'($urandom_range(0, 1));
        eerr = exp_err(we, f3, a);
        elat = exp_lat(k, we, f3, a);
        idx  = int'(a[9:2]);
        erd  = (!we && !eerr) ? exp_load(model_mem[k][idx], f3, a) : 32'd0;
        run_txn(k, we, f3, a, wd, perturb, lat, rd, er, nwr, rs, bs, sb, sa, sv, rdy);
        if (we && !eerr) model_mem[k][idx] = exp_store(model_mem[k][idx], f3, a, wd);
        checks++;
        if (lat !== elat || er !== eerr || rd !== erd)
          $display("FAIL rand_resp inst=%0d n=%0d got lat=%0d err=%0d rdata=%08h want lat=%0d err=%0d rdata=%08h",
                   k, n, lat, er, rd, elat, eerr, erd);
        else passes++;
        m = (64'd1 << (elat + 1)) - 64'd1;
        checks++;
        if ((sb & m) !== ((64'd1 << elat) - 64'd1) || rdy !== 1'b1)
          $display("FAIL rand_stall inst=%0d n=%0d got stall=%h ready=%0d want stall=%h ready=1",
                   k, n, sb & m, rdy, (64'd1 << elat) - 64'd1);
        else passes++;
        checks++;
        if (nwr !== ((we && !eerr) ? 1 : 0) || bs || rs !== (!eerr && (!we || f3 != 2)))
          $display("FAIL rand_strobes inst=%0d n=%0d got writes=%0d read=%0d overlap=%0d", k, n, nwr, rs, bs);
        else passes++;
        if (!eerr) begin
          checks++;
          if (sa !== {a[31:2], 2'b00} || sv || mem[k][idx] !== model_mem[k][idx])
            $display("FAIL rand_mem inst=%0d n=%0d got addr=%08h varied=%0d word=%08h want addr=%08h word=%08h",
                     k, n, sa, sv, mem[k][idx], {a[31:2], 2'b00}, model_mem[k][idx]);
          else passes++;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_funct3[k] = 3'd0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; bd_we[k] = 1'b0; bd_idx[k] = 8'd0; bd_data[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    test_reset_mid_rmw();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_back_to_back();
    test_input_change();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
